// File: rtl/rng_request_scheduler.sv
// Round-robin scheduler sharing one RNG core among NUM_REQ requesters.
// Issues a generate strobe, returns the captured word, and inserts periodic reseed windows.
module rng_request_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int TIMEOUT         = 15,
  parameter int RESEED_INTERVAL = 64,
  parameter int RESEED_CYCLES   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_err,
  output logic                       rng_enable,
  input  logic                       rng_valid,
  input  logic [DATA_WIDTH-1:0]      rng_data,
  output logic                       reseed_req,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SUM_W = ID_W + 2;
  localparam int TM_W  = 8;
  localparam int WC_W  = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;
  localparam int RC_W  = $clog2(RESEED_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    RESEED  = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [NUM_REQ-1:0]    gnt_reg, gnt_next;
  logic [ID_W-1:0]       gnt_id_reg, gnt_id_next;
  logic [ID_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [TM_W-1:0]       timer_reg, timer_next;
  logic [WC_W-1:0]       word_cnt_reg, word_cnt_next;
  logic [RC_W-1:0]       rs_cnt_reg, rs_cnt_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic [ID_W-1:0]       rsp_id_reg, rsp_id_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic                  rng_enable_reg, rng_enable_next;
  logic                  reseed_req_reg, reseed_req_next;
  logic                  busy_reg, busy_next;

  logic                  pick_valid;
  logic [ID_W-1:0]       pick_id;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [SUM_W-1:0]      cand;
  logic                  reseed_due;

  // Scan from the far end so the closest requester after rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = SUM_W'(rr_ptr_reg) + SUM_W'(i) + SUM_W'(1);
      if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
      if (req[cand[ID_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = cand[ID_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign pick_onehot[gi] = pick_valid && (pick_id == ID_W'(gi));
  end

  assign reseed_due = (RESEED_INTERVAL != 0) && (word_cnt_reg == WC_W'(RESEED_INTERVAL));

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    gnt_id_next     = gnt_id_reg;
    rr_ptr_next     = rr_ptr_reg;
    timer_next      = timer_reg;
    word_cnt_next   = word_cnt_reg;
    rs_cnt_next     = rs_cnt_reg;
    rsp_valid_next  = 1'b0;
    rsp_data_next   = rsp_data_reg;
    rsp_id_next     = rsp_id_reg;
    rsp_err_next    = rsp_err_reg;
    rng_enable_next = 1'b0;
    reseed_req_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (reseed_due) begin
          state_next      = RESEED;
          rs_cnt_next     = '0;
          reseed_req_next = 1'b1;
          word_cnt_next   = '0;
          gnt_next        = '0;
        end else if (pick_valid) begin
          state_next      = ISSUE;
          gnt_next        = pick_onehot;
          gnt_id_next     = pick_id;
          rng_enable_next = 1'b1;
        end
      end
      ISSUE: begin
        state_next = WAIT;
        timer_next = '0;
      end
      WAIT: begin
        if (rng_valid) begin
          state_next     = DELIVER;
          rsp_valid_next = 1'b1;
          rsp_data_next  = rng_data;
          rsp_id_next    = gnt_id_reg;
          rsp_err_next   = 1'b0;
        end else if (timer_reg == TM_W'(TIMEOUT - 1)) begin
          state_next     = DELIVER;
          rsp_valid_next = 1'b1;
          rsp_data_next  = '0;
          rsp_id_next    = gnt_id_reg;
          rsp_err_next   = 1'b1;
        end else begin
          timer_next = timer_reg + TM_W'(1);
        end
      end
      DELIVER: begin
        state_next  = IDLE;
        gnt_next    = '0;
        rr_ptr_next = gnt_id_reg;
        // Failed transactions do not count toward the reseed interval.
        if (!rsp_err_reg && (word_cnt_reg != WC_W'(RESEED_INTERVAL)))
          word_cnt_next = word_cnt_reg + WC_W'(1);
      end
      RESEED: begin
        if (rs_cnt_reg == RC_W'(RESEED_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          rs_cnt_next     = rs_cnt_reg + RC_W'(1);
          reseed_req_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      gnt_id_reg     <= '0;
      rr_ptr_reg     <= ID_W'(NUM_REQ - 1);
      timer_reg      <= '0;
      word_cnt_reg   <= '0;
      rs_cnt_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_id_reg     <= '0;
      rsp_err_reg    <= 1'b0;
      rng_enable_reg <= 1'b0;
      reseed_req_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      gnt_id_reg     <= gnt_id_next;
      rr_ptr_reg     <= rr_ptr_next;
      timer_reg      <= timer_next;
      word_cnt_reg   <= word_cnt_next;
      rs_cnt_reg     <= rs_cnt_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_data_reg   <= rsp_data_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_err_reg    <= rsp_err_next;
      rng_enable_reg <= rng_enable_next;
      reseed_req_reg <= reseed_req_next;
      busy_reg       <= busy_next;
    end
  end

  assign gnt        = gnt_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_err    = rsp_err_reg;
  assign rng_enable = rng_enable_reg;
  assign reseed_req = reseed_req_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_rng_request_scheduler.sv
// Bench for rng_request_scheduler: reset, table of directed transactions, mid-op reset,
// then randomized transactions checked against a transaction-level round-robin model.
module tb_rng_request_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int TO   = 15;
  localparam int RI   = 2;
  localparam int RC   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_id;
  logic          rsp_err;
  logic          rng_enable;
  logic          rng_valid;
  logic [DW-1:0] rng_data;
  logic          reseed_req;
  logic          busy;

  int total = 0;
  int bad   = 0;

  rng_request_scheduler #(
    .NUM_REQ(NREQ), .DATA_WIDTH(DW), .TIMEOUT(TO),
    .RESEED_INTERVAL(RI), .RESEED_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rng_enable(rng_enable), .rng_valid(rng_valid), .rng_data(rng_data),
    .reseed_req(reseed_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pat;
    int          d;
    logic [15:0] data;
    bit          exp_rs;
    int          exp_id;
    bit          exp_err;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at the negedge of a cycle in which the DUT is idle; returns in the next idle cycle.
  task automatic do_txn(input logic [3:0] pat, input int d, input logic [15:0] data,
                        input bit exp_rs, input int exp_id, input bit exp_err,
                        input logic [15:0] exp_data);
    logic [3:0] oh;
    int nwait;
    oh = 4'(1 << exp_id);
    req = pat;
    rng_valid = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    if (exp_rs) begin
      for (int k = 0; k < RC; k++) begin
        step();
        chk("reseed_req_on", 32'(reseed_req), 1);
        chk("reseed_gnt", 32'(gnt), 0);
        chk("reseed_rng_enable", 32'(rng_enable), 0);
      end
      step();
      chk("reseed_req_off", 32'(reseed_req), 0);
      chk("reseed_busy_off", 32'(busy), 0);
    end
    if (pat == 4'd0) begin
      step();
      chk("noreq_busy", 32'(busy), 0);
      chk("noreq_enable", 32'(rng_enable), 0);
      chk("noreq_gnt", 32'(gnt), 0);
      req = '0;
      return;
    end
    step();
    chk("issue_gnt", 32'(gnt), 32'(oh));
    chk("issue_enable", 32'(rng_enable), 1);
    chk("issue_busy", 32'(busy), 1);
    chk("issue_rsp_valid", 32'(rsp_valid), 0);
    req = 4'($urandom_range(0, 15));
    rng_valid = 1'($urandom_range(0, 1));
    rng_data = 16'($urandom);
    step();
    nwait = (d < TO) ? d : TO - 1;
    for (int w = 0; w <= nwait; w++) begin
      chk("wait_gnt", 32'(gnt), 32'(oh));
      chk("wait_enable", 32'(rng_enable), 0);
      chk("wait_rsp_valid", 32'(rsp_valid), 0);
      if (d < TO && w == d) begin
        rng_valid = 1'b1;
        rng_data = data;
      end else begin
        rng_valid = 1'b0;
        rng_data = 16'($urandom);
      end
      step();
    end
    chk("dlv_rsp_valid", 32'(rsp_valid), 1);
    chk("dlv_rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("dlv_rsp_id", 32'(rsp_id), 32'(exp_id));
    chk("dlv_rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("dlv_gnt", 32'(gnt), 32'(oh));
    rng_valid = 1'b1;
    rng_data = 16'($urandom);
    step();
    chk("post_gnt", 32'(gnt), 0);
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_rsp_data_hold", 32'(rsp_data), 32'(exp_data));
    chk("post_rsp_id_hold", 32'(rsp_id), 32'(exp_id));
    chk("post_busy", 32'(busy), 0);
    rng_valid = 1'b0;
    req = '0;
  endtask

  initial begin
    int m_last, m_wc, id, d, c;
    logic [3:0] pat;
    logic [15:0] data;
    bit rs, err;

    tbl[0]  = '{4'b0100,  0, 16'hBEEF, 1'b0, 2, 1'b0, 16'hBEEF};
    tbl[1]  = '{4'b1111,  2, 16'h1234, 1'b0, 3, 1'b0, 16'h1234};
    tbl[2]  = '{4'b1111, 20, 16'hDEAD, 1'b1, 0, 1'b1, 16'h0000};
    tbl[3]  = '{4'b1111,  1, 16'h5A5A, 1'b0, 1, 1'b0, 16'h5A5A};
    tbl[4]  = '{4'b1111, 14, 16'h0F0F, 1'b0, 2, 1'b0, 16'h0F0F};
    tbl[5]  = '{4'b1111,  0, 16'h7777, 1'b1, 3, 1'b0, 16'h7777};
    tbl[6]  = '{4'b1111,  3, 16'h0001, 1'b0, 0, 1'b0, 16'h0001};
    tbl[7]  = '{4'b0001,  0, 16'hFFFF, 1'b1, 0, 1'b0, 16'hFFFF};
    tbl[8]  = '{4'b1000, 15, 16'h1111, 1'b0, 3, 1'b1, 16'h0000};
    tbl[9]  = '{4'b0110,  1, 16'hABCD, 1'b0, 1, 1'b0, 16'hABCD};
    tbl[10] = '{4'b0110,  0, 16'hCAFE, 1'b1, 2, 1'b0, 16'hCAFE};
    tbl[11] = '{4'b0000,  0, 16'h0000, 1'b0, 0, 1'b0, 16'h0000};

    rst = 1'b1;
    req = 4'hF;
    rng_valid = 1'b0;
    rng_data = '0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_enable", 32'(rng_enable), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_reseed", 32'(reseed_req), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      do_txn(tbl[i].pat, tbl[i].d, tbl[i].data, tbl[i].exp_rs,
             tbl[i].exp_id, tbl[i].exp_err, tbl[i].exp_data);

    // Reset while waiting on the RNG.
    req = 4'b0010;
    step();
    chk("mid_issue_gnt", 32'(gnt), 32'(4'b0010));
    req = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    for (int k = 0; k < 3; k++) begin
      rng_valid = 1'b1;
      rng_data = 16'($urandom);
      step();
      chk("mid_after_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_after_busy", 32'(busy), 0);
    end
    rng_valid = 1'b0;
    do_txn(4'b1010, 2, 16'h4242, 1'b0, 1, 1'b0, 16'h4242);

    m_last = 1;
    m_wc = 1;
    for (int n = 0; n < 40; n++) begin
      pat = 4'($urandom_range(0, 15));
      d = int'($urandom_range(0, TO + 3));
      data = 16'($urandom);
      rs = (m_wc == RI);
      if (rs) m_wc = 0;
      id = 0;
      err = 1'b0;
      if (pat != 4'd0) begin
        for (int k = NREQ; k >= 1; k--) begin
          c = (m_last + k) % NREQ;
          if (pat[c]) id = c;
        end
        err = (d >= TO);
        m_last = id;
        if (!err && m_wc < RI) m_wc++;
      end
      do_txn(pat, d, data, rs, id, err, err ? 16'h0000 : data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
